// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Brief    : Shared widths, opcode constants and state encoding for the
//            ALU arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  // Datapath and opcode widths shared by the arbiter and the ALU
  localparam int DW_DEFAULT  = 16;
  localparam int OPW_DEFAULT = 2;

  // ALU opcodes; OP_RSV bypasses the ALU and flags an error
  localparam logic [OPW_DEFAULT-1:0] OP_ADD = 2'b00;
  localparam logic [OPW_DEFAULT-1:0] OP_SUB = 2'b01;
  localparam logic [OPW_DEFAULT-1:0] OP_INC = 2'b10;
  localparam logic [OPW_DEFAULT-1:0] OP_RSV = 2'b11;

  // Result-register occupancy
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_alu
// Brief    : Combinational execute-stage ALU: add / sub / increment with
//            zero flag and carry/borrow out of bit DW.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int OPW = OPW_DEFAULT
) (
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] op,
  output logic [DW-1:0]  result,
  output logic           zero,
  output logic           ovf
);

  logic [DW:0] w_sum;

  // DW+1-bit unsigned arithmetic; bit DW carries the carry (add/inc) or borrow (sub)
  always_comb begin
    w_sum = '0;
    case (op)
      OP_ADD:  w_sum = {1'b0, a} + {1'b0, b};
      OP_SUB:  w_sum = {1'b0, a} - {1'b0, b};
      OP_INC:  w_sum = {1'b0, a} + {{DW{1'b0}}, 1'b1};
      default: w_sum = '0;
    endcase
  end

  assign result = w_sum[DW-1:0];
  assign zero   = (w_sum[DW-1:0] == '0);
  assign ovf    = w_sum[DW];

endmodule : alu_arbiter_alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin arbiter sharing one ALU between the execute pipe
//            (requester 0) and the PC-increment path (requester 1), with a
//            single registered result stage and valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int OPW = OPW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_z,
  output logic           rsp_ovf,
  output logic           rsp_err
);

  // Registered state
  state_t          r_state;
  logic            r_last_grant;
  logic [1:0]      r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic            r_rsp_z;
  logic            r_rsp_ovf;
  logic            r_rsp_err;

  // Next-state values
  state_t          w_state_nxt;
  logic            w_last_grant_nxt;
  logic [1:0]      w_rsp_valid_nxt;
  logic [DW-1:0]   w_rsp_data_nxt;
  logic            w_rsp_z_nxt;
  logic            w_rsp_ovf_nxt;
  logic            w_rsp_err_nxt;

  // Arbitration and handshake
  logic            w_drain;
  logic            w_can_accept;
  logic            w_grant;
  logic            w_grant_valid;
  logic            w_accept;

  // ALU operand mux and outputs
  logic [DW-1:0]   w_alu_a;
  logic [DW-1:0]   w_alu_b;
  logic [OPW-1:0]  w_alu_op;
  logic [DW-1:0]   w_alu_result;
  logic            w_alu_zero;
  logic            w_alu_ovf;
  logic            w_is_rsv;

  // A consume strobe only counts when it targets the current owner
  assign w_drain      = (r_state == ST_FULL) && ((r_rsp_valid & rsp_ready) != 2'b00);
  assign w_can_accept = (r_state == ST_EMPTY) || w_drain;

  // Round-robin pick: contention goes to whoever did not win last time
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_grant_valid = w_grant ? req1_valid : req0_valid;
  assign w_accept      = w_can_accept && w_grant_valid;
  assign req0_ready    = w_can_accept && !w_grant;
  assign req1_ready    = w_can_accept &&  w_grant;

  assign w_alu_a  = w_grant ? req1_a  : req0_a;
  assign w_alu_b  = w_grant ? req1_b  : req0_b;
  assign w_alu_op = w_grant ? req1_op : req0_op;
  assign w_is_rsv = (w_alu_op == OP_RSV);

  alu_arbiter_alu #(
    .DW  (DW),
    .OPW (OPW)
  ) u_alu (
    .a      (w_alu_a),
    .b      (w_alu_b),
    .op     (w_alu_op),
    .result (w_alu_result),
    .zero   (w_alu_zero),
    .ovf    (w_alu_ovf)
  );

  // Next-state: accept overwrites the result stage (even while draining), else drain empties it
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_z_nxt      = r_rsp_z;
    w_rsp_ovf_nxt    = r_rsp_ovf;
    w_rsp_err_nxt    = r_rsp_err;
    if (w_accept) begin
      w_state_nxt      = ST_FULL;
      w_last_grant_nxt = w_grant;
      w_rsp_valid_nxt  = w_grant ? 2'b10 : 2'b01;
      w_rsp_data_nxt   = w_is_rsv ? '0   : w_alu_result;
      w_rsp_z_nxt      = w_is_rsv ? 1'b1 : w_alu_zero;
      w_rsp_ovf_nxt    = w_is_rsv ? 1'b0 : w_alu_ovf;
      w_rsp_err_nxt    = w_is_rsv;
    end else if (w_drain) begin
      w_state_nxt     = ST_EMPTY;
      w_rsp_valid_nxt = 2'b00;
    end
  end

  // State and result register; async reset discards any pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 2'b00;
      r_rsp_data   <= '0;
      r_rsp_z      <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_z      <= w_rsp_z_nxt;
      r_rsp_ovf    <= w_rsp_ovf_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_z     = r_rsp_z;
  assign rsp_ovf   = r_rsp_ovf;
  assign rsp_err   = r_rsp_err;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter: directed steps followed by
//            randomized traffic, compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int DW  = 16;
  localparam int OPW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic [1:0]     rsp_valid, rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic           rsp_z, rsp_ovf, rsp_err;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_z      (rsp_z),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err)
  );

  int checks = 0;
  int passes = 0;

  // Behavioural model: one result slot with an owner, plus who won last
  bit          m_full;
  int          m_owner;
  logic [15:0] m_data;
  bit          m_z, m_ovf, m_err;
  int          m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_full = 0; m_owner = 0; m_data = 16'h0;
    m_z = 0; m_ovf = 0; m_err = 0; m_last = 1;
  endtask

  // Integer-arithmetic reference: returns {err, ovf, z, data}
  function automatic logic [18:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua, ub, full;
    bit o, e;
    logic [15:0] d;
    ua = a; ub = b; o = 0; e = 0; full = 0;
    case (op)
      2'd0: begin full = ua + ub; o = (full > 65535); end
      2'd1: begin o = (ua < ub); full = o ? (ua + 65536 - ub) : (ua - ub); end
      2'd2: begin full = ua + 1; o = (full > 65535); end
      default: begin full = 0; o = 0; e = 1; end
    endcase
    d = 16'(full % 65536);
    return {e, o, (d == 16'h0), d};
  endfunction

  task automatic drive(input bit v0, input logic [1:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                       input bit v1, input logic [1:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                       input logic [1:0] rr);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
  endtask

  // One clock: check readies mid-cycle, then registered outputs just after the edge
  task automatic cycle(input string tag);
    bit drain, can, acc;
    int g;
    logic [18:0] r;
    @(negedge clk);
    drain = m_full && rsp_ready[m_owner];
    can   = !m_full || drain;
    if (req0_valid && req1_valid) g = 1 - m_last;
    else if (req1_valid)          g = 1;
    else                          g = 0;
    chk({tag, ".req0_ready"}, {31'b0, req0_ready}, {31'b0, (can && g == 0)});
    chk({tag, ".req1_ready"}, {31'b0, req1_ready}, {31'b0, (can && g == 1)});
    acc = can && ((g == 0) ? req0_valid : req1_valid);
    @(posedge clk);
    #1;
    if (acc) begin
      r = (g == 0) ? ref_alu(req0_op, req0_a, req0_b) : ref_alu(req1_op, req1_a, req1_b);
      m_full = 1; m_owner = g; m_last = g;
      m_err = r[18]; m_ovf = r[17]; m_z = r[16]; m_data = r[15:0];
    end else if (drain) begin
      m_full = 0;
    end
    chk({tag, ".rsp_valid"}, {30'b0, rsp_valid}, m_full ? ((m_owner == 1) ? 32'd2 : 32'd1) : 32'd0);
    chk({tag, ".rsp_data"},  {16'b0, rsp_data},  {16'b0, m_data});
    chk({tag, ".rsp_z"},     {31'b0, rsp_z},     {31'b0, m_z});
    chk({tag, ".rsp_ovf"},   {31'b0, rsp_ovf},   {31'b0, m_ovf});
    chk({tag, ".rsp_err"},   {31'b0, rsp_err},   {31'b0, m_err});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 2'd0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 16'h0, 2'b00);
    model_reset();
    #12;
    chk("reset.rsp_valid", {30'b0, rsp_valid}, 32'd0);
    chk("reset.rsp_data",  {16'b0, rsp_data},  32'd0);
    chk("reset.flags",     {29'b0, rsp_z, rsp_ovf, rsp_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-requester arithmetic corner cases
    drive(1, 2'd0, 16'h0003, 16'h0004, 0, 2'd0, 16'h0, 16'h0, 2'b11);
    cycle("add3p4");
    chk("add3p4.data", {16'b0, rsp_data}, 32'h0007);
    chk("add3p4.vld",  {30'b0, rsp_valid}, 32'd1);
    drive(1, 2'd0, 16'hFFFF, 16'h0001, 0, 2'd0, 16'h0, 16'h0, 2'b11);
    cycle("addwrap");
    chk("addwrap.zo", {30'b0, rsp_z, rsp_ovf}, 32'd3);
    drive(1, 2'd2, 16'h7FFF, 16'h1234, 0, 2'd0, 16'h0, 16'h0, 2'b11);
    cycle("inc7fff");
    chk("inc7fff.data", {16'b0, rsp_data}, 32'h8000);
    drive(0, 2'd0, 16'h0, 16'h0, 1, 2'd1, 16'h0005, 16'h0005, 2'b11);
    cycle("sub5m5");
    chk("sub5m5.vz", {29'b0, rsp_valid, rsp_z}, 32'b101);
    drive(0, 2'd0, 16'h0, 16'h0, 1, 2'd1, 16'h0000, 16'h0001, 2'b11);
    cycle("sub0m1");
    chk("sub0m1.data", {16'b0, rsp_data}, 32'hFFFF);
    chk("sub0m1.ovf",  {31'b0, rsp_ovf}, 32'd1);

    // Continuous contention: strict alternation with no bubbles
    for (int i = 0; i < 6; i++) begin
      drive(1, 2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
            1, 2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 2'b11);
      cycle("alt");
      chk("alt.owner", {30'b0, rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Backpressure: owner 0 not consuming, requester 1 waiting
    drive(1, 2'd0, 16'h0100, 16'h0023, 0, 2'd0, 16'h0, 16'h0, 2'b11);
    cycle("bp.load");
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'd0, 16'h0, 16'h0, 1, 2'd0, 16'h1111, 16'h2222, 2'b00);
      cycle("bp.hold");
      chk("bp.hold.data", {16'b0, rsp_data}, 32'h0123);
    end
    drive(0, 2'd0, 16'h0, 16'h0, 1, 2'd0, 16'h1111, 16'h2222, 2'b10);
    cycle("bp.wrongbit");
    chk("bp.wrongbit.vld", {30'b0, rsp_valid}, 32'd1);
    drive(0, 2'd0, 16'h0, 16'h0, 1, 2'd0, 16'h1111, 16'h2222, 2'b01);
    cycle("bp.release");
    chk("bp.release.data", {16'b0, rsp_data}, 32'h3333);
    chk("bp.release.vld",  {30'b0, rsp_valid}, 32'd2);

    // Reserved opcode, then asynchronous reset while FULL
    drive(0, 2'd0, 16'h0, 16'h0, 1, 2'd3, 16'hABCD, 16'h1234, 2'b11);
    cycle("rsv");
    chk("rsv.all", {16'b0, rsp_data[12:0], rsp_z, rsp_ovf, rsp_err}, 32'b101);
    drive(0, 2'd0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 16'h0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.rsp_valid", {30'b0, rsp_valid}, 32'd0);
    chk("arst.err",       {31'b0, rsp_err},   32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 2'd0, 16'h0001, 16'h0001, 1, 2'd2, 16'h0009, 16'h0, 2'b11);
    cycle("post_rst");
    chk("post_rst.first", {30'b0, rsp_valid}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 2'($urandom), 16'($urandom_range(0, 3) == 0 ? 16'hFFFF : $urandom), 16'($urandom),
            1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 16'h0 : $urandom),
            2'($urandom));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 16-bit execute-stage ALU (add / sub / increment, with zero and overflow flags) between two requesters.
  - Requester 0: main execute pipe.
  - Requester 1: PC/address-increment path.
- Round-robin arbitration, valid/ready handshakes on request and response sides, one registered result stage.
- Instantiates the existing ALU module; owns all sequencing around it.

Parameters:
- DW, 16, operand/result width; must match the ALU datapath width.
- OPW, 2, opcode width (00 add, 01 sub, 10 increment a, 11 reserved).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  DW each  requester 0 operands.
- req0_op  input  OPW  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  output  2  one-hot: result register holds a result for requester 0 (bit0) or 1 (bit1).
- rsp_ready  input  2  per-requester result consume strobe.
- rsp_data  output  DW  registered ALU result.
- rsp_z  output  1  registered zero flag.
- rsp_ovf  output  1  registered carry/borrow (bit DW of the DW+1 result).
- rsp_err  output  1  registered: reserved opcode was issued.

Behaviour:
- Reset: state=EMPTY, rsp_valid=00, rsp_data=0, rsp_z=0, rsp_ovf=0, rsp_err=0, last_grant=1 (requester 0 wins first contention).
- State machine, states EMPTY and FULL:
  - drain = FULL && (rsp_valid & rsp_ready) != 0; a rsp_ready bit for the non-owner is ignored.
  - can_accept = EMPTY || drain.
- Grant, combinational:
  - Only one valid, and can_accept: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - reqX_ready = can_accept && grant==X. ready may depend on valid; requesters must not make valid depend on ready.
- Accept cycle (valid && ready):
  - Operands/op of the granted requester are muxed into the ALU.
  - Result, z, ovf captured into the result register at that clock edge.
  - rsp_valid set one-hot to the owner; last_grant updated; state=FULL.
  - Latency: accept at edge N, rsp_valid high after edge N. Throughput 1 op/cycle while the owner holds rsp_ready high.
- Drain without new accept: state=EMPTY, rsp_valid=00. rsp_data/flags hold their last values (don't-care).
- Drain and accept in the same cycle: the result register is overwritten with the new op. rsp_valid switches directly to the new owner with no bubble.
- FULL and not drained: register and rsp_valid hold; both reqX_ready=0 (backpressure).
- Reserved op 11: accepted normally; the ALU is not used for it. rsp_data=0, rsp_z=1, rsp_ovf=0, rsp_err=1. rsp_err=0 for legal ops.
- Arithmetic, DW+1-bit unsigned:
  - add: a+b.
  - sub: a-b, two's complement; bit DW set on borrow.
  - inc: a+1; b ignored.
  - z = (low DW bits == 0).
- Inputs change while valid && !ready: no effect; sampling only occurs on accept.
- Reset asserted mid-operation: pending result discarded immediately (async), all outputs return to reset values, last_grant=1.
- No starvation: with both requesters continuously valid and rsp_ready high, grants strictly alternate 0,1,0,1...

Decomposition:
- Shared package:
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_INC=2'b10, OP_RSV=2'b11.
  - State encoding ST_EMPTY, ST_FULL.
  - DW default.
- Sub-module: the existing ALU instance, used combinationally.
- The round-robin grant logic may be split into a small rr_grant2 sub-module; optional.

Test Plan:
- Req0 add a=0x0003 b=0x0004, rsp_ready=11 -> next cycle rsp_valid=01, rsp_data=0x0007, z=0, ovf=0, err=0.
- Req1 sub 0x0005-0x0005 -> rsp_valid=10, rsp_data=0x0000, z=1. Req1 sub 0x0000-0x0001 -> rsp_data=0xFFFF, ovf=1, z=0.
- Req0 add 0xFFFF+0x0001 -> rsp_data=0x0000, z=1, ovf=1. Req0 inc a=0x7FFF -> rsp_data=0x8000, ovf=0.
- Both valid every cycle for 6 cycles, rsp_ready=11, distinct ops -> grants 0,1,0,1,0,1; rsp_valid alternates 01/10 with no bubbles; each rsp_data matches its op.
- Req0 add accepted, rsp_ready=00 for 3 cycles with req1 valid -> rsp held unchanged, req1_ready=0. Raise rsp_ready[0] -> req1 accepted the same cycle, its result the next cycle. rsp_ready[1] alone while owner is 0 -> no drain.
- Op 11 from req1 -> rsp_data=0, z=1, ovf=0, err=1. Then assert rst_n=0 while FULL -> rsp_valid=00 immediately. After release, simultaneous requests -> req0 granted first.
